debug_reg_dumper: RTL and testbench

Debug-side sequencer that freezes the pipeline and reads the whole register bank through the instruction-decode debug read port, one register at a time. It serializes the contents into a framed byte stream on a valid/ready interface that feeds the UART transmitter. It sits between the instruction-decode stage (halt, register-read address, register content, program-end flag) and the debug unit's TX path. It is the requesting end of the decode stage's debug read interface.

---
 rtl/debug_reg_dumper.sv | 183 ++++++++++++++++++
 tb/tb_debug_reg_dumper.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_dumper.sv
// Debug register dumper: halts the pipeline, walks the register bank through the
// decode debug read port and streams a framed, MSB-first byte dump to the TX path.
module debug_reg_dumper #(
    parameter int          NUM_REGS    = 32,
    parameter int          ADDR_WIDTH  = 5,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int          AUTO_DUMP   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_program_end,
    input  logic [DATA_WIDTH-1:0] i_reg_content,
    output logic [ADDR_WIDTH-1:0] o_reg_read,
    output logic                  o_halt,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        HEADER = 3'd2,
        LOAD   = 3'd3,
        SEND   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] index_r;
    logic [ADDR_WIDTH-1:0] index_n;
    logic [ADDR_WIDTH-1:0] reg_read_n;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_n;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic [7:0]            tx_data_n;
    logic                  tx_valid_n;
    logic                  halt_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  pend_prev_r;

    logic                  pend_rise_s;
    logic                  trigger_s;
    logic                  handshake_s;
    logic                  last_reg_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [7:0]            next_byte_s;

    // Only the rising edge of program-end counts, so a level held high never retriggers.
    assign pend_rise_s = (AUTO_DUMP != 0) && i_program_end && !pend_prev_r;
    assign trigger_s   = i_start || pend_rise_s;
    assign handshake_s = o_tx_valid && i_tx_ready;
    assign last_reg_s  = (index_r == ADDR_WIDTH'(NUM_REGS - 1));
    assign shifted_s   = shift_r << 4'd8;
    assign next_byte_s = shifted_s[DATA_WIDTH-1 -: 8];

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_n    = state_r;
        index_n    = index_r;
        reg_read_n = o_reg_read;
        shift_n    = shift_r;
        cnt_n      = cnt_r;
        tx_data_n  = o_tx_data;
        tx_valid_n = o_tx_valid;
        halt_n     = o_halt;
        busy_n     = o_busy;
        done_n     = 1'b0;

        case (state_r)
            IDLE: begin
                if (trigger_s) begin
                    state_n    = SETTLE;
                    halt_n     = 1'b1;
                    busy_n     = 1'b1;
                    index_n    = {ADDR_WIDTH{1'b0}};
                    reg_read_n = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_n    = IDLE;
                end
            end
            SETTLE: begin
                // Decode switches its read mux this cycle; header goes out next.
                state_n    = HEADER;
                tx_data_n  = HEADER_BYTE;
                tx_valid_n = 1'b1;
            end
            HEADER: begin
                if (handshake_s) begin
                    state_n    = LOAD;
                    tx_valid_n = 1'b0;
                end else begin
                    state_n    = HEADER;
                end
            end
            LOAD: begin
                state_n    = SEND;
                shift_n    = i_reg_content;
                cnt_n      = CNT_WIDTH'(NUM_BYTES - 1);
                tx_data_n  = i_reg_content[DATA_WIDTH-1 -: 8];
                tx_valid_n = 1'b1;
            end
            SEND: begin
                if (handshake_s) begin
                    if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        tx_valid_n = 1'b0;
                        if (last_reg_s) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            state_n    = LOAD;
                            index_n    = index_r + ADDR_WIDTH'(1);
                            reg_read_n = o_reg_read + ADDR_WIDTH'(1);
                        end
                    end else begin
                        // Next byte is presented immediately, no bubble.
                        shift_n   = shifted_s;
                        tx_data_n = next_byte_s;
                        cnt_n     = cnt_r - CNT_WIDTH'(1);
                    end
                end else begin
                    state_n = SEND;
                end
            end
            DONE: begin
                state_n    = IDLE;
                halt_n     = 1'b0;
                busy_n     = 1'b0;
                index_n    = {ADDR_WIDTH{1'b0}};
                reg_read_n = {ADDR_WIDTH{1'b0}};
                tx_valid_n = 1'b0;
            end
            default: begin
                state_n    = IDLE;
                halt_n     = 1'b0;
                busy_n     = 1'b0;
                index_n    = {ADDR_WIDTH{1'b0}};
                reg_read_n = {ADDR_WIDTH{1'b0}};
                tx_valid_n = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any dump in progress.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= IDLE;
            index_r     <= {ADDR_WIDTH{1'b0}};
            shift_r     <= {DATA_WIDTH{1'b0}};
            cnt_r       <= {CNT_WIDTH{1'b0}};
            pend_prev_r <= 1'b0;
            o_reg_read  <= {ADDR_WIDTH{1'b0}};
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_halt      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_r     <= state_n;
            index_r     <= index_n;
            shift_r     <= shift_n;
            cnt_r       <= cnt_n;
            pend_prev_r <= i_program_end;
            o_reg_read  <= reg_read_n;
            o_tx_data   <= tx_data_n;
            o_tx_valid  <= tx_valid_n;
            o_halt      <= halt_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
        end
    end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Scoreboard bench for debug_reg_dumper: stimulus pushes expected frame bytes,
// a negedge monitor pops them on every TX handshake and tracks halt/done timing.
module tb_debug_reg_dumper;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pend = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] regs [NR];
    logic [31:0] reg_content;
    logic [4:0]  reg_read;
    logic        halt, tx_valid, busy, done;
    logic [7:0]  tx_data;

    logic [4:0]  reg_read2;
    logic        halt2, tx_valid2, busy2, done2;
    logic [7:0]  tx_data2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int done_count = 0;
    int done_cyc = 0;
    int halt_rise = 0;
    int halt_fall = 0;
    int stalls = 0;
    int bytes_seen = 0;
    int d0 = 0;
    logic bp_mode = 1'b0;
    logic busy2_seen = 1'b0;
    logic [7:0] exp_q [$];

    assign reg_content = regs[reg_read];

    debug_reg_dumper dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_program_end(pend),
        .i_reg_content(reg_content), .o_reg_read(reg_read), .o_halt(halt),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_busy(busy), .o_done(done)
    );

    debug_reg_dumper #(.AUTO_DUMP(0)) dut_noauto (
        .i_clk(clk), .i_reset(rst), .i_start(1'b0), .i_program_end(pend),
        .i_reg_content(32'h0), .o_reg_read(reg_read2), .o_halt(halt2),
        .o_tx_data(tx_data2), .o_tx_valid(tx_valid2), .i_tx_ready(1'b1),
        .o_busy(busy2), .o_done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected frame: header then each register MSB first.
    task automatic push_frame();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NR; k++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(regs[k][8*b +: 8]);
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_count == base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_send(input logic [4:0] r);
        int n = 0;
        while (!(reg_read == r && tx_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_wait_timeout", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Ready generator: held high, or toggled every cycle in backpressure mode.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_mode) ready = ~ready;
            else ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops on handshakes, tracks stalls, stability, halt and done.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        logic       halt_prev;
        stall_prev = 1'b0;
        stall_data = 8'h00;
        halt_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (busy2) busy2_seen = 1'b1;
            if (rst) begin
                stall_prev = 1'b0;
                halt_prev  = 1'b0;
            end else begin
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (halt && !halt_prev) halt_rise = cyc;
                if (!halt && halt_prev) halt_fall = cyc;
                halt_prev = halt;
                if (stall_prev && tx_valid) check("hold_stable", {24'h0, tx_data}, {24'h0, stall_data});
                if (tx_valid && !ready) begin
                    stall_prev = 1'b1;
                    stall_data = tx_data;
                    stalls++;
                end else begin
                    stall_prev = 1'b0;
                end
                if (tx_valid && ready) begin
                    bytes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_byte actual=%0h required=none (cyc %0d)", tx_data, cyc);
                    end else begin
                        check("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        regs[0] = 32'h0;
        for (int k = 1; k < NR; k++) regs[k] = 32'hA0B0C000 + k;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_halt", {31'h0, halt}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_reg_read", {27'h0, reg_read}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full dump, ready held high
        d0 = done_count;
        bytes_seen = 0;
        push_frame();
        start_pulse();
        check("busy_after_start", {31'h0, busy}, 32'd1);
        wait_done(d0);
        check("full_done_cyc", done_cyc, t0 + 163);
        check("full_halt_rise", halt_rise, t0 + 1);
        check("full_halt_fall", halt_fall, t0 + 164);
        check("full_bytes", bytes_seen, 32'd129);
        check("full_q_empty", exp_q.size(), 32'd0);
        check("full_single_done", done_count, d0 + 1);
        check("idle_busy", {31'h0, busy}, 32'd0);

        // Backpressure: ready toggles every cycle
        d0 = done_count;
        bytes_seen = 0;
        stalls = 0;
        push_frame();
        bp_mode = 1'b1;
        start_pulse();
        wait_done(d0);
        bp_mode = 1'b0;
        check("bp_stalls_seen", (stalls > 0) ? 32'd1 : 32'd0, 32'd1);
        check("bp_done_cyc", done_cyc, t0 + 163 + stalls);
        check("bp_bytes", bytes_seen, 32'd129);
        check("bp_q_empty", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);

        // Auto trigger on program-end rising edge; level held high
        d0 = done_count;
        bytes_seen = 0;
        push_frame();
        @(posedge clk); #1;
        pend = 1'b1;
        t0 = cyc;
        wait_done(d0);
        check("auto_done_cyc", done_cyc, t0 + 163);
        repeat (300) @(posedge clk);
        check("auto_no_retrigger", done_count, d0 + 1);
        check("auto_idle", {31'h0, busy}, 32'd0);
        check("auto_bytes", bytes_seen, 32'd129);
        check("auto_q_empty", exp_q.size(), 32'd0);
        pend = 1'b0;
        repeat (3) @(posedge clk);

        // Start pulsed during SEND of register 7 is ignored
        d0 = done_count;
        bytes_seen = 0;
        push_frame();
        start_pulse();
        wait_send(5'd7);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (20) @(posedge clk);
        check("ign_single_done", done_count, d0 + 1);
        check("ign_bytes", bytes_seen, 32'd129);
        check("ign_q_empty", exp_q.size(), 32'd0);

        // Simultaneous start and program-end edge: one frame
        d0 = done_count;
        bytes_seen = 0;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1;
        pend = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (200) @(posedge clk);
        check("simul_done_cyc", done_cyc, t0 + 163);
        check("simul_single_done", done_count, d0 + 1);
        check("simul_bytes", bytes_seen, 32'd129);
        check("simul_q_empty", exp_q.size(), 32'd0);
        pend = 1'b0;
        repeat (3) @(posedge clk);

        // Asynchronous reset during SEND of register 12
        push_frame();
        start_pulse();
        wait_send(5'd12);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_mid_halt", {31'h0, halt}, 32'd0);
        check("rst_mid_busy", {31'h0, busy}, 32'd0);
        exp_q.delete();
        d0 = done_count;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);
        check("rst_mid_no_done", done_count, d0);

        // Fresh dump after reset
        d0 = done_count;
        bytes_seen = 0;
        push_frame();
        start_pulse();
        wait_done(d0);
        check("post_rst_done_cyc", done_cyc, t0 + 163);
        check("post_rst_bytes", bytes_seen, 32'd129);
        check("post_rst_q_empty", exp_q.size(), 32'd0);

        check("noauto_never_busy", {31'h0, busy2_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
